shift_register_sequencer: RTL

- Command-driven controller that sequences a WIDTH-bit universal shift register (mode select s1/s0, serial MSB_in/LSB_in, parallel I_par).
- Accepts one command at a time over a valid/ready handshake: parallel load, logical shift, rotate or arithmetic shift-right by N positions.
- Drives the register one operation per clock, monitors the register's parallel output for rotate/arithmetic feedback, and pulses done on completion.

---
 rtl/shift_register_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/shift_register_sequencer.sv
// Command-driven sequencer for a WIDTH-bit universal shift register: load, shift, rotate, ASR by N.
// Optional abort input/abort_flag output when SHREG_SEQ_ABORT_EN is defined.
module shift_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] A_par,
`ifdef SHREG_SEQ_ABORT_EN
    input  logic             abort,
    output logic             abort_flag,
`endif
    output logic             s1,
    output logic             s0,
    output logic             MSB_in,
    output logic             LSB_in,
    output logic [WIDTH-1:0] I_par,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    state_t             state_q;
    logic [CNT_W-1:0]   rem_q;
    logic               busy_q, done_q, err_q, ready_q;
    logic [2:0]         op_q;
    logic               fill_q;
    logic [WIDTH-1:0]   data_q;
    logic               accept;
    logic               abort_hit;
    logic               is_shift;
    logic               unused_apar;

    // Only the end bits of A_par feed back; the rest is intentionally unobserved.
    assign unused_apar = ^A_par;

`ifdef SHREG_SEQ_ABORT_EN
    logic abort_flag_q;
    assign abort_flag = abort_flag_q;
    assign abort_hit  = abort && (state_q == LOAD || state_q == SHIFT);
`else
    assign abort_hit  = 1'b0;
`endif

    assign accept    = cmd_valid && ready_q && (state_q == IDLE);
    assign is_shift  = (cmd_op >= OP_SHR) && (cmd_op <= OP_ASR);
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            op_q    <= OP_HOLD;
`ifdef SHREG_SEQ_ABORT_EN
            abort_flag_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef SHREG_SEQ_ABORT_EN
            abort_flag_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= cmd_op;
                        rem_q   <= cmd_count;
                        ready_q <= 1'b0;
                        if (cmd_op == OP_LOAD) begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end else if (is_shift && cmd_count != '0) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= (cmd_op == OP_ILL);
                        end
                    end
                end
                LOAD: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
`ifdef SHREG_SEQ_ABORT_EN
                    abort_flag_q <= abort_hit;
`endif
                end
                SHIFT: begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (abort_hit || rem_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef SHREG_SEQ_ABORT_EN
                        abort_flag_q <= abort_hit;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Command payload is plain data; it only matters while the FSM is in LOAD/SHIFT.
    always_ff @(posedge CLK) begin
        if (accept && !Clear) begin
            fill_q <= cmd_fill;
            data_q <= cmd_data;
        end
    end

    always_comb begin
        s1     = 1'b0;
        s0     = 1'b0;
        MSB_in = 1'b0;
        LSB_in = 1'b0;
        I_par  = '0;
        if (state_q == LOAD) begin
            s1    = 1'b1;
            s0    = 1'b1;
            I_par = data_q;
        end else if (state_q == SHIFT) begin
            case (op_q)
                OP_SHR: begin s0 = 1'b1; MSB_in = fill_q;           end
                OP_SHL: begin s1 = 1'b1; LSB_in = fill_q;           end
                OP_ROR: begin s0 = 1'b1; MSB_in = A_par[0];         end
                OP_ROL: begin s1 = 1'b1; LSB_in = A_par[WIDTH-1];   end
                OP_ASR: begin s0 = 1'b1; MSB_in = A_par[WIDTH-1];   end
                default: ;
            endcase
        end
        // An abort suppresses the register update in the cycle it is seen.
        if (abort_hit) begin
            s1 = 1'b0;
            s0 = 1'b0;
        end
    end

endmodule
